// File: rtl/illm_row_sequencer_pkg.sv
// Shared definitions for the IDCT row sequencer: FSM encoding, token width
// and the lane-index width helper.
package illm_row_sequencer_pkg;

    localparam logic [1:0] ST_RUN         = 2'd0;
    localparam logic [1:0] ST_EOS_COLLECT = 2'd1;
    localparam logic [1:0] ST_EOS_EMIT    = 2'd2;
    localparam logic [1:0] ST_ERR         = 2'd3;

    localparam int DEF_DATA_W = 9;

    // A token is one sample plus its end-of-stream flag.
    function automatic int tok_w(input int data_w);
        return data_w + 1;
    endfunction

    localparam int TOK_W = tok_w(DEF_DATA_W);

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/illm_seq_outreg.sv
// Single-entry output holding register; can_load is asserted whenever the
// slot is empty or is being drained on this edge.
module illm_seq_outreg #(
    parameter int DATA_W = 9,
    parameter int LANE_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_d,
    input  logic              load_e,
    input  logic [LANE_W-1:0] load_lane,
    input  logic              out_b,
    output logic              out_v,
    output logic [DATA_W-1:0] out_d,
    output logic              out_e,
    output logic [LANE_W-1:0] out_lane,
    output logic              can_load
);

    logic              v_reg;
    logic [DATA_W-1:0] d_reg;
    logic              e_reg;
    logic [LANE_W-1:0] lane_reg;

    assign can_load = !v_reg || !out_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_reg    <= 1'b0;
            d_reg    <= '0;
            e_reg    <= 1'b0;
            lane_reg <= '0;
        end else if (load) begin
            v_reg    <= 1'b1;
            d_reg    <= load_d;
            e_reg    <= load_e;
            lane_reg <= load_lane;
        end else if (!out_b) begin
            v_reg    <= 1'b0;
        end
    end

    assign out_v    = v_reg;
    assign out_d    = d_reg;
    assign out_e    = e_reg;
    assign out_lane = lane_reg;

endmodule

// File: rtl/illm_row_sequencer.sv
// Drains the per-lane token queues of an IDCT row page in strict lane order
// onto one stream, collapsing a row-aligned EOS into a single token.
module illm_row_sequencer
    import illm_row_sequencer_pkg::*;
#(
    parameter int N_LANES = 8,
    parameter int DATA_W  = 9,
    parameter int CNT_W   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_LANES*DATA_W-1:0]   in_d,
    input  logic [N_LANES-1:0]          in_e,
    input  logic [N_LANES-1:0]          in_v,
    output logic [N_LANES-1:0]          in_b,
    output logic [DATA_W-1:0]           out_d,
    output logic                        out_e,
    output logic                        out_v,
    input  logic                        out_b,
    output logic [clog2(N_LANES)-1:0]   out_lane,
    output logic [CNT_W-1:0]            row_cnt,
    output logic                        err
);

    localparam int LANE_W = clog2(N_LANES);
    localparam int TW     = tok_w(DATA_W);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

    logic [1:0]        state_reg;
    logic [LANE_W-1:0] ptr_reg;
    logic [CNT_W-1:0]  row_cnt_reg;
    logic              err_reg;
    logic [DATA_W-1:0] eos_d_reg;

    logic [TW-1:0]     lane_tok [N_LANES];
    logic [TW-1:0]     sel_tok;
    logic              sel_e;
    logic [DATA_W-1:0] sel_d;
    logic              ptr_block;
    logic              take;
    logic              can_load;
    logic              load;
    logic [DATA_W-1:0] load_d;
    logic              load_e;
    logic [LANE_W-1:0] load_lane;

    // Non-selected lanes are always blocked; reset blocks every lane.
    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign lane_tok[gi] = {in_e[gi], in_d[gi*DATA_W +: DATA_W]};
            assign in_b[gi]     = !reset || (ptr_reg != LANE_W'(gi)) || ptr_block;
        end
    endgenerate

    always_comb begin
        ptr_block = 1'b1;
        case (state_reg)
            ST_RUN:         ptr_block = !can_load;
            ST_EOS_COLLECT: ptr_block = 1'b0;
            default:        ptr_block = 1'b1;
        endcase
    end

    assign sel_tok = lane_tok[ptr_reg];
    assign sel_e   = sel_tok[TW-1];
    assign sel_d   = sel_tok[DATA_W-1:0];
    assign take    = in_v[ptr_reg] && !ptr_block;

    assign load      = ((state_reg == ST_RUN) && take && !sel_e) ||
                       ((state_reg == ST_EOS_EMIT) && can_load);
    assign load_e    = (state_reg == ST_EOS_EMIT);
    assign load_d    = load_e ? eos_d_reg : sel_d;
    assign load_lane = load_e ? '0 : ptr_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_RUN;
            ptr_reg     <= '0;
            row_cnt_reg <= '0;
            err_reg     <= 1'b0;
            eos_d_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (take) begin
                        if (!sel_e) begin
                            ptr_reg <= ptr_reg + LANE_W'(1);
                            if (ptr_reg == LAST_LANE) begin
                                row_cnt_reg <= row_cnt_reg + CNT_W'(1);
                            end
                        end else if (ptr_reg == '0) begin
                            eos_d_reg <= sel_d;
                            ptr_reg   <= LANE_W'(1);
                            state_reg <= ST_EOS_COLLECT;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_ERR;
                        end
                    end
                end
                ST_EOS_COLLECT: begin
                    if (take) begin
                        if (!sel_e) begin
                            err_reg   <= 1'b1;
                            state_reg <= ST_ERR;
                        end else if (ptr_reg == LAST_LANE) begin
                            ptr_reg   <= '0;
                            state_reg <= ST_EOS_EMIT;
                        end else begin
                            ptr_reg <= ptr_reg + LANE_W'(1);
                        end
                    end
                end
                ST_EOS_EMIT: begin
                    if (can_load) begin
                        row_cnt_reg <= '0;
                        state_reg   <= ST_RUN;
                    end
                end
                default: begin
                    state_reg <= ST_ERR;
                end
            endcase
        end
    end

    illm_seq_outreg #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_outreg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_d    (load_d),
        .load_e    (load_e),
        .load_lane (load_lane),
        .out_b     (out_b),
        .out_v     (out_v),
        .out_d     (out_d),
        .out_e     (out_e),
        .out_lane  (out_lane),
        .can_load  (can_load)
    );

    assign row_cnt = row_cnt_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_illm_row_sequencer.sv
// Directed bench for illm_row_sequencer (CNT_W=4 so the row counter wraps
// within a short run).
module tb_illm_row_sequencer;

    localparam int N  = 8;
    localparam int DW = 9;
    localparam int CW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N*DW-1:0]   in_d;
    logic [N-1:0]      in_e;
    logic [N-1:0]      in_v;
    logic [N-1:0]      in_b;
    logic [DW-1:0]     out_d;
    logic              out_e;
    logic              out_v;
    logic              out_b;
    logic [2:0]        out_lane;
    logic [CW-1:0]     row_cnt;
    logic              err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    illm_row_sequencer #(
        .N_LANES (N),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_d     (in_d),
        .in_e     (in_e),
        .in_v     (in_v),
        .in_b     (in_b),
        .out_d    (out_d),
        .out_e    (out_e),
        .out_v    (out_v),
        .out_b    (out_b),
        .out_lane (out_lane),
        .row_cnt  (row_cnt),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lanes(input int base, input logic [N-1:0] v, input logic [N-1:0] e);
        for (int i = 0; i < N; i++) begin
            in_d[i*DW +: DW] = DW'(base + i);
        end
        in_v = v;
        in_e = e;
    endtask

    task automatic expect_tok(input string tag, input int lane, input int d, input logic e);
        chk({tag, "_v"}, 32'(out_v), 32'd1);
        chk({tag, "_d"}, 32'(out_d), 32'(d));
        chk({tag, "_lane"}, 32'(out_lane), 32'(lane));
        chk({tag, "_e"}, 32'(out_e), 32'(e));
        $display("%0t %s: lane=%0d d=%03h e=%0b row_cnt=%0d", $time, tag, out_lane, out_d, out_e, row_cnt);
    endtask

    initial begin
        logic [31:0] rv;
        logic [CW-1:0] exp_cnt;
        int exp_lane;
        int rows_done;
        int cycles;

        in_d  = '0;
        in_e  = '0;
        in_v  = '0;
        out_b = 1'b0;

        // Reset state
        #2;
        chk("rst_out_v", 32'(out_v), 0);
        chk("rst_out_d", 32'(out_d), 0);
        chk("rst_out_e", 32'(out_e), 0);
        chk("rst_out_lane", 32'(out_lane), 0);
        chk("rst_in_b", 32'(in_b), 32'hFF);
        chk("rst_err", 32'(err), 0);
        chk("rst_row_cnt", 32'(row_cnt), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("idle_in_b", 32'(in_b), 32'hFE);

        // Basic row
        set_lanes(10, 8'hFF, 8'h00);
        for (int k = 0; k < N; k++) begin
            tick();
            expect_tok("row1", k, 10 + k, 1'b0);
        end
        chk("row1_cnt", 32'(row_cnt), 1);
        in_v = '0;
        tick();
        chk("row1_drain", 32'(out_v), 0);

        // Back-pressure on lane 2 while lane 1's token is held
        set_lanes(20, 8'hFF, 8'h00);
        tick();
        expect_tok("row2", 0, 20, 1'b0);
        tick();
        expect_tok("row2", 1, 21, 1'b0);
        out_b = 1'b1;
        #1;
        chk("bp_in_b2", 32'(in_b[2]), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_tok("bp_hold", 1, 21, 1'b0);
            chk("bp_in_b2_hold", 32'(in_b[2]), 1);
        end
        out_b = 1'b0;
        #1;
        chk("bp_release_in_b2", 32'(in_b[2]), 0);
        for (int k = 2; k < N; k++) begin
            tick();
            expect_tok("row2", k, 20 + k, 1'b0);
        end
        chk("row2_cnt", 32'(row_cnt), 2);

        // Aligned EOS
        set_lanes(0, 8'hFF, 8'hFF);
        in_d[0 +: DW] = 9'h1AB;
        for (int k = 0; k < N; k++) begin
            tick();
            chk("eos_collect_quiet", 32'(out_v), 0);
        end
        set_lanes(30, 8'hFF, 8'h00);
        #1;
        chk("eos_emit_in_b", 32'(in_b), 32'hFF);
        tick();
        expect_tok("eos", 0, 32'h1AB, 1'b1);
        chk("eos_row_cnt", 32'(row_cnt), 0);
        for (int k = 0; k < N; k++) begin
            tick();
            expect_tok("row3", k, 30 + k, 1'b0);
        end
        chk("row3_cnt", 32'(row_cnt), 1);

        // Sparse random valids across 17 rows; counter wraps 15 -> 0
        exp_cnt   = 4'd1;
        exp_lane  = 0;
        rows_done = 0;
        cycles    = 0;
        while (rows_done < 17 && cycles < 4000) begin
            rv = $urandom;
            set_lanes(rows_done * 8, rv[N-1:0], 8'h00);
            tick();
            cycles++;
            if (rv[exp_lane]) begin
                expect_tok("sparse", exp_lane, (rows_done * 8 + exp_lane) % 512, 1'b0);
                if (exp_lane == N - 1) begin
                    exp_lane  = 0;
                    rows_done = rows_done + 1;
                    exp_cnt   = exp_cnt + 4'd1;
                end else begin
                    exp_lane = exp_lane + 1;
                end
            end else begin
                chk("sparse_gap", 32'(out_v), 0);
            end
            chk("sparse_row_cnt", 32'(row_cnt), 32'(exp_cnt));
        end
        in_v = '0;
        tick();
        chk("sparse_drain", 32'(out_v), 0);

        // Misaligned EOS on lane 3
        set_lanes(40, 8'hFF, 8'h08);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_tok("mis", k, 40 + k, 1'b0);
        end
        chk("mis_err_before", 32'(err), 0);
        tick();
        chk("mis_err", 32'(err), 1);
        chk("mis_in_b", 32'(in_b), 32'hFF);
        chk("mis_drained", 32'(out_v), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("err_quiet", 32'(out_v), 0);
            chk("err_sticky", 32'(err), 1);
            chk("err_in_b", 32'(in_b), 32'hFF);
        end

        // Async reset clears the error immediately
        #2;
        reset = 1'b0;
        #1;
        chk("rst_err_clr", 32'(err), 0);
        chk("rst_err_in_b", 32'(in_b), 32'hFF);
        chk("rst_err_row_cnt", 32'(row_cnt), 0);

        // Async reset mid-EOS_COLLECT
        @(negedge clock);
        set_lanes(0, 8'hFF, 8'hFF);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("collect_quiet", 32'(out_v), 0);
        end
        chk("collect_in_b", 32'(in_b), 32'hF7);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_collect_out_v", 32'(out_v), 0);
        chk("rst_collect_in_b", 32'(in_b), 32'hFF);
        chk("rst_collect_err", 32'(err), 0);
        @(negedge clock);
        set_lanes(60, 8'hFF, 8'h00);
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            tick();
            expect_tok("fresh", k, 60 + k, 1'b0);
        end
        chk("fresh_cnt", 32'(row_cnt), 1);
        in_v = '0;
        tick();
        chk("fresh_drain", 32'(out_v), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/illm_row_sequencer.md
Name: illm_row_sequencer

Overview:
- Scheduler that drains the eight per-lane token queues of an IDCT row page (one 9-bit sample plus an end-of-stream flag per token) in strict lane order 0..N_LANES-1.
- Serializes them onto one valid/back-pressure output stream tagged with the lane index.
- Sits between the page's output queues and the downstream single-stream consumer.
- Enforces row-aligned end-of-stream across all lanes and collapses the N per-lane EOS tokens into one.

Parameters:
- N_LANES, 8, number of input lanes (power of 2, ≥2)
- DATA_W, 9, sample width excluding the EOS flag
- CNT_W, 16, width of the completed-row counter

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_d  in  N_LANES*DATA_W  packed lane data; lane i at [i*DATA_W +: DATA_W]
- in_e  in  N_LANES  per-lane end-of-stream flag
- in_v  in  N_LANES  per-lane valid
- in_b  out  N_LANES  per-lane back-pressure (1 = cannot accept)
- out_d  out  DATA_W  serialized sample
- out_e  out  1  end-of-stream flag
- out_v  out  1  output valid
- out_b  in  1  downstream back-pressure
- out_lane  out  log2(N_LANES)  source lane of the current output token
- row_cnt  out  CNT_W  completed rows since reset or since the last EOS; wraps modulo 2^CNT_W
- err  out  1  sticky protocol-error flag

Behaviour:
- **Reset (reset=0, async).**
  - State RUN, ptr=0, row_cnt=0, err=0.
  - Output register empty: out_v=0, out_d=0, out_e=0, out_lane=0.
  - in_b all 1 while reset is asserted.
  - Reset mid-row or mid-EOS discards partial progress; a held output token is dropped.
- **Handshake.**
  - A transfer occurs on a clock edge where v=1 and b=0.
  - can_load = !out_v || !out_b. The output register loads exactly when can_load and a source token is taken.
  - Latency is 1 cycle from input acceptance to out_v.
  - Full throughput: one token per cycle while out_b=0.
- **in_b rule.** in_b[i]=1 for every i≠ptr in all states. For i=ptr:
  - RUN: in_b = !can_load.
  - EOS_COLLECT: in_b = 0.
  - EOS_EMIT and ERR: in_b = 1.
- **RUN state.** Accepted token at lane ptr:
  - e=0:
    - Load out_d=data, out_e=0, out_lane=ptr.
    - ptr increments. On wrap N_LANES-1→0, row_cnt increments.
  - e=1 with ptr=0:
    - Capture the data as eos_d; ptr=1.
    - Go to EOS_COLLECT. Nothing is emitted.
  - e=1 with ptr≠0:
    - err=1, go to ERR. The token is consumed and not emitted.
- **EOS_COLLECT state.**
  - Consumes from lane ptr independent of output state.
  - e=1: ptr increments. After lane N_LANES-1, go to EOS_EMIT with ptr=0.
  - e=0: err=1, go to ERR. The token is discarded.
- **EOS_EMIT state.**
  - When can_load: load out_d=eos_d, out_e=1, out_lane=0.
  - Same edge: row_cnt=0, return to RUN.
- **ERR state.**
  - All in_b=1. No further loads.
  - The held output token still drains normally.
  - err stays 1 until reset.
- **Simultaneous events.**
  - Output drain and new load on the same edge are permitted: out_v stays 1.
  - in_v on non-selected lanes is ignored.
  - in_v may deassert mid-row; ptr holds.
- **Output stability.** out_d, out_e and out_lane are held while out_v=1 && out_b=1.

Decomposition:
- Shared package holds:
  - state encoding (RUN, EOS_COLLECT, EOS_EMIT, ERR);
  - token width constant DATA_W+1;
  - lane-index width function clog2.
- One natural sub-module, illm_seq_outreg: the single-entry output holding register with can_load generation.
- The FSM, pointer and counter remain in the top.

Test Plan:
- **Basic row.** Lanes 0..7 all valid with data 10+i, out_b=0.
  - Outputs d=10..17, lane=0..7, on consecutive cycles starting 1 cycle after the first acceptance.
  - row_cnt=1 after the eighth.
- **Back-pressure.** Hold out_b=1 for 3 cycles while lane 2 presents.
  - out_d/out_lane are stable.
  - in_b[2]=1 during the stall.
  - Exactly one acceptance follows release; there is no duplicate or loss.
- **Aligned EOS.** After 2 rows, every lane presents e=1, with lane 0 d=0x1AB.
  - No output for 8 collect cycles, then one token: out_e=1, d=0x1AB, lane=0.
  - row_cnt=0.
  - The following row streams normally.
- **Misaligned EOS.** Lane 3 presents e=1 mid-row.
  - err=1 next cycle; all in_b=1.
  - The previously held lane-2 token still drains.
  - No further out_v after that.
- **Sparse valid and wrap.** Lane valids arrive in random order with gaps across 2^CNT_W+1 rows (CNT_W=4 variant).
  - Output lane order is strictly 0..7.
  - row_cnt wraps 15→0.
- **Async reset mid-EOS_COLLECT.** Assert reset asynchronously mid-clock.
  - Immediately: out_v=0, in_b all 1, err=0.
  - After release, a fresh row starting at lane 0 is accepted.
